// File: rtl/uart_rx_packet_ctrl_if.sv
// rtl/uart_rx_packet_ctrl_if.sv - receiver byte stream, payload stream and error status bundle
interface uart_rx_packet_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;
    logic       frame_err;
    logic [7:0] err_count;

    modport master (
        output rx_data, rx_valid, out_ready,
        input  rx_ready, out_data, out_valid, out_last, frame_err, err_count
    );

    modport slave (
        input  rx_data, rx_valid, out_ready,
        output rx_ready, out_data, out_valid, out_last, frame_err, err_count
    );
endinterface

// File: rtl/uart_rx_packet_ctrl.sv
// rtl/uart_rx_packet_ctrl.sv - frames uart bytes into checksummed packets and streams the payload
module uart_rx_packet_ctrl #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         MAX_LEN   = 16,
    parameter int         TIMEOUT   = 64
) (
    input  logic                 CLKIN,
    input  logic                 reset,
    input  logic                 clock_enable,
    uart_rx_packet_ctrl_if.slave bus
);
    // Buffer index width (at least one bit) and pointer width able to hold MAX_LEN itself.
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int PW = $clog2(MAX_LEN) + 1;
    localparam int GW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CSUM    = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    state_t          state_q;
    logic [PW-1:0]   len_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [7:0]      sum_q;
    logic [GW-1:0]   gap_q;
    logic            rx_ready_q;
    logic            out_valid_q;
    logic            out_last_q;
    logic [7:0]      out_data_q;
    logic            frame_err_q;
    logic [7:0]      err_count_q;
    logic [7:0]      buf_q [2**AW];

    logic            byte_in;
    logic            len_ok;
    logic            gap_expired;
    logic            err_d;
    logic [PW-1:0]   wr_ptr_d;
    logic [PW-1:0]   rd_ptr_d;

    // Qualify the incoming byte and decide whether this tick ends the frame in error.
    always_comb begin
        byte_in     = clock_enable && bus.rx_valid;
        len_ok      = (bus.rx_data != 8'd0) && (bus.rx_data <= 8'(MAX_LEN));
        gap_expired = !bus.rx_valid && (gap_q == GW'(TIMEOUT - 1));
        wr_ptr_d    = wr_ptr_q + PW'(1);
        rd_ptr_d    = rd_ptr_q + PW'(1);
        err_d       = 1'b0;
        case (state_q)
            LEN:     err_d = gap_expired || (bus.rx_valid && !len_ok);
            PAYLOAD: err_d = gap_expired;
            CSUM:    err_d = gap_expired || (bus.rx_valid && (bus.rx_data != sum_q));
            default: err_d = 1'b0;
        endcase
    end

    // Frame sequencer: hunt for sync, collect length/payload/checksum, then drain the buffer.
    always_ff @(posedge CLKIN) begin
        if (reset) begin
            state_q     <= HUNT;
            len_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            sum_q       <= 8'd0;
            gap_q       <= '0;
            rx_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= 8'd0;
            frame_err_q <= 1'b0;
            err_count_q <= 8'd0;
        end else if (clock_enable) begin
            frame_err_q <= err_d;
            if (err_d && (err_count_q != 8'hFF)) begin
                err_count_q <= err_count_q + 8'd1;
            end

            // Gap counter only matters while a frame is being collected.
            if (state_q == LEN || state_q == PAYLOAD || state_q == CSUM) begin
                gap_q <= bus.rx_valid ? '0 : gap_q + GW'(1);
            end

            case (state_q)
                HUNT: begin
                    if (byte_in && (bus.rx_data == SYNC_BYTE)) begin
                        state_q <= LEN;
                        gap_q   <= '0;
                    end
                end
                LEN: begin
                    if (err_d) begin
                        state_q <= HUNT;
                    end else if (byte_in) begin
                        len_q    <= PW'(bus.rx_data);
                        sum_q    <= bus.rx_data;
                        wr_ptr_q <= '0;
                        state_q  <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (err_d) begin
                        state_q <= HUNT;
                    end else if (byte_in) begin
                        buf_q[wr_ptr_q[AW-1:0]] <= bus.rx_data;
                        sum_q    <= sum_q + bus.rx_data;
                        wr_ptr_q <= wr_ptr_d;
                        if (wr_ptr_d == len_q) begin
                            state_q <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (err_d) begin
                        state_q <= HUNT;
                    end else if (byte_in) begin
                        state_q     <= DRAIN;
                        rd_ptr_q    <= '0;
                        rx_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        out_data_q  <= buf_q[0];
                        out_last_q  <= (len_q == PW'(1));
                    end
                end
                DRAIN: begin
                    // Receiver bytes are ignored here; only the consumer handshake moves us.
                    if (out_valid_q && bus.out_ready) begin
                        if (out_last_q) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            rx_ready_q  <= 1'b1;
                            state_q     <= HUNT;
                        end else begin
                            rd_ptr_q   <= rd_ptr_d;
                            out_data_q <= buf_q[rd_ptr_d[AW-1:0]];
                            out_last_q <= ((rd_ptr_q + PW'(2)) == len_q);
                        end
                    end
                end
                default: state_q <= HUNT;
            endcase
        end
    end

    assign bus.rx_ready  = rx_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_data  = out_data_q;
    assign bus.frame_err = frame_err_q;
    assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
// tb/tb_uart_rx_packet_ctrl.sv - directed scoreboard bench for uart_rx_packet_ctrl
module tb_uart_rx_packet_ctrl;
    logic CLKIN;
    logic reset;
    logic clock_enable;
    int   checks;
    int   failures;
    logic [8:0] exp_q [$];

    uart_rx_packet_ctrl_if ifc ();

    uart_rx_packet_ctrl #(
        .SYNC_BYTE (8'hA5),
        .MAX_LEN   (16),
        .TIMEOUT   (64)
    ) dut (
        .CLKIN        (CLKIN),
        .reset        (reset),
        .clock_enable (clock_enable),
        .bus          (ifc.slave)
    );

    initial begin
        CLKIN = 1'b0;
        forever #5 CLKIN = ~CLKIN;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLKIN);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        ifc.rx_data  = b;
        ifc.rx_valid = 1'b1;
        tick();
        ifc.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drain_all();
        int budget;
        budget = 0;
        ifc.out_ready = 1'b1;
        while ((exp_q.size() != 0 || ifc.out_valid) && budget < 40) begin
            tick();
            budget++;
        end
        chk("drain_done", exp_q.size(), 0);
        chk("drain_out_valid", ifc.out_valid, 1'b0);
        chk("drain_rx_ready", ifc.rx_ready, 1'b1);
        ifc.out_ready = 1'b0;
    endtask

    // Scoreboard side: every accepted payload byte must match the head of the expected queue.
    always @(negedge CLKIN) begin
        if (!reset && clock_enable && ifc.out_valid && ifc.out_ready) begin
            chk("out_expected", (exp_q.size() != 0), 1'b1);
            if (exp_q.size() != 0) begin
                chk("out_data", ifc.out_data, exp_q[0][7:0]);
                chk("out_last", ifc.out_last, exp_q[0][8]);
                chk("rx_ready_in_drain", ifc.rx_ready, 1'b0);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        clock_enable = 1'b1;
        ifc.rx_data = 8'd0;
        ifc.rx_valid = 1'b0;
        ifc.out_ready = 1'b0;
        idle(2);
        reset = 1'b0;
        chk("rst_rx_ready", ifc.rx_ready, 1'b1);
        chk("rst_out_valid", ifc.out_valid, 1'b0);
        chk("rst_out_last", ifc.out_last, 1'b0);
        chk("rst_out_data", ifc.out_data, 8'h00);
        chk("rst_frame_err", ifc.frame_err, 1'b0);
        chk("rst_err_count", ifc.err_count, 8'h00);

        // 1: three-byte frame; checksum = 03+11+22+33 = 69
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b0, 8'h22});
        exp_q.push_back({1'b1, 8'h33});
        send_byte(8'h69);
        chk("t1_latency_valid", ifc.out_valid, 1'b1);
        chk("t1_first_data", ifc.out_data, 8'h11);
        chk("t1_rx_ready_low", ifc.rx_ready, 1'b0);
        ifc.out_ready = 1'b1;
        idle(3);
        chk("t1_consecutive", exp_q.size(), 0);
        chk("t1_valid_drop", ifc.out_valid, 1'b0);
        chk("t1_rx_ready_back", ifc.rx_ready, 1'b1);
        chk("t1_err_count", ifc.err_count, 8'd0);
        ifc.out_ready = 1'b0;

        // 2: bad checksum (02+10+20 = 32, sent 31), then good single-byte frame
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h31);
        chk("t2_frame_err", ifc.frame_err, 1'b1);
        chk("t2_err_count", ifc.err_count, 8'd1);
        chk("t2_no_valid", ifc.out_valid, 1'b0);
        tick();
        chk("t2_err_pulse_end", ifc.frame_err, 1'b0);
        chk("t2_still_no_valid", ifc.out_valid, 1'b0);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7F);
        exp_q.push_back({1'b1, 8'h7F});
        send_byte(8'h80);
        drain_all();

        // 3: zero length and over-length
        send_byte(8'hA5); send_byte(8'h00);
        chk("t3_len0_err", ifc.frame_err, 1'b1);
        chk("t3_len0_count", ifc.err_count, 8'd2);
        send_byte(8'hA5); send_byte(8'h11);
        chk("t3_len17_err", ifc.frame_err, 1'b1);
        chk("t3_len17_count", ifc.err_count, 8'd3);
        chk("t3_rx_ready", ifc.rx_ready, 1'b1);

        // 4: gap timeout at 64 idle ticks; 63-tick gaps are tolerated
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01);
        idle(63);
        chk("t4_no_err_63", ifc.frame_err, 1'b0);
        tick();
        chk("t4_err_64", ifc.frame_err, 1'b1);
        chk("t4_err_count", ifc.err_count, 8'd4);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01);
        idle(63);
        send_byte(8'h02);
        idle(63);
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b1, 8'h02});
        send_byte(8'h05);
        chk("t4_gap63_no_err", ifc.err_count, 8'd4);
        chk("t4_gap63_valid", ifc.out_valid, 1'b1);
        drain_all();

        // 5: backpressure 0,1,0,0,1 with a 5-cycle clock_enable freeze mid-drain
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'hC3); send_byte(8'h3C);
        exp_q.push_back({1'b0, 8'hC3});
        exp_q.push_back({1'b1, 8'h3C});
        send_byte(8'h01);
        ifc.out_ready = 1'b0;
        tick();
        chk("t5_hold_data0", ifc.out_data, 8'hC3);
        ifc.out_ready = 1'b1;
        tick();
        chk("t5_second_data", ifc.out_data, 8'h3C);
        chk("t5_second_last", ifc.out_last, 1'b1);
        clock_enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_freeze_valid", ifc.out_valid, 1'b1);
            chk("t5_freeze_data", ifc.out_data, 8'h3C);
            chk("t5_freeze_last", ifc.out_last, 1'b1);
        end
        clock_enable = 1'b1;
        ifc.out_ready = 1'b0;
        tick();
        tick();
        chk("t5_hold_data1", ifc.out_data, 8'h3C);
        chk("t5_hold_valid1", ifc.out_valid, 1'b1);
        ifc.out_ready = 1'b1;
        tick();
        chk("t5_done", exp_q.size(), 0);
        chk("t5_valid_drop", ifc.out_valid, 1'b0);
        ifc.out_ready = 1'b0;

        // 6: reset mid-payload and mid-drain
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6a_out_valid", ifc.out_valid, 1'b0);
        chk("t6a_rx_ready", ifc.rx_ready, 1'b1);
        chk("t6a_err_count", ifc.err_count, 8'd0);
        send_byte(8'h00); send_byte(8'hFF);
        chk("t6a_garbage_err", ifc.frame_err, 1'b0);
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h0C);
        exp_q.push_back({1'b0, 8'h0A});
        send_byte(8'h24);
        chk("t6b_in_drain", ifc.out_valid, 1'b1);
        tick();
        reset = 1'b1;
        exp_q.delete();
        tick();
        reset = 1'b0;
        chk("t6b_out_valid", ifc.out_valid, 1'b0);
        chk("t6b_rx_ready", ifc.rx_ready, 1'b1);
        chk("t6b_err_count", ifc.err_count, 8'd0);
        send_byte(8'h00); send_byte(8'hFF);
        chk("t6b_garbage_err", ifc.err_count, 8'd0);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h42);
        exp_q.push_back({1'b1, 8'h42});
        send_byte(8'h43);
        drain_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
